// File: rtl/div_seq.sv
// Sequential restoring divider (one quotient bit per clock) with its own sequencer
// and pipeline stall request. Optional early-out path enabled by DIV_EARLY_OUT_EN.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_BYZERO, S_END} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd, dvs;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_nx, dvd_nx, q_fix, r_fix;
  logic             last, early, go, zero_dvs;

  always_comb begin
    abs1     = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs2     = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    go       = start_i && !annul_i;
    zero_dvs = (opdata2_i == '0);
    // trial is WIDTH+1 bits; its top bit is the sign because rem < dvs always holds
    shifted  = {rem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    rem_nx   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_nx   = {dvd[WIDTH-2:0], ~trial[WIDTH]};
    q_fix    = neg_q ? -dvd_nx : dvd_nx;
    r_fix    = neg_r ? -rem_nx : rem_nx;
    last     = (cnt == CW'(WIDTH - 1));
  end

`ifdef DIV_EARLY_OUT_EN
  assign early = (abs1 < abs2);
`else
  assign early = 1'b0;
`endif

  assign stallreq_o = start_i && !annul_i && !ready_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (go) begin
        if (zero_dvs)   state_next = S_BYZERO;
        else if (early) state_next = S_END;
        else            state_next = S_ON;
      end
      S_ON:     if (annul_i) state_next = S_IDLE;
                else if (last) state_next = S_END;
      S_BYZERO: state_next = annul_i ? S_IDLE : S_END;
      S_END:    if (annul_i || !start_i) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= (state_next == S_END);
      case (state)
        S_IDLE: if (go) begin
          cnt   <= '0;
          rem   <= '0;
          dvd   <= zero_dvs ? opdata1_i : abs1;
          dvs   <= abs2;
          neg_q <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_r <= signed_i && opdata1_i[WIDTH-1];
          if (!zero_dvs && early) result_o <= {opdata1_i, {WIDTH{1'b0}}};
        end
        S_ON: if (!annul_i) begin
          cnt <= cnt + CW'(1);
          rem <= rem_nx;
          dvd <= dvd_nx;
          // final iteration and sign fix share the edge into END
          if (last) result_o <= {r_fix, q_fix};
        end
        S_BYZERO: if (!annul_i) result_o <= {dvd, {WIDTH{1'b1}}};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: vector table plus annul/reset sequences.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0, annul_i = 1'b0, signed_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
    .signed_i(signed_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    bit          eo;
  } vec_t;

  vec_t        vec [11];
  logic [63:0] last_res;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Counts edges until ready_o (bounded) and cycles with stall high before it.
  task automatic wait_ready(output int n, output int nst);
    n = 0;
    nst = 0;
    #1;
    while (!ready_o && n < 100) begin
      if (stallreq_o) nst++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_div(input int id, input vec_t v);
    int n, nst, lat;
    lat = (EARLY && v.eo) ? 1 : v.lat;
    @(negedge clk);
    signed_i = v.sgn; opdata1_i = v.a; opdata2_i = v.b; start_i = 1'b1;
    wait_ready(n, nst);
    chk($sformatf("v%0d_latency", id), 64'(n), 64'(lat));
    chk($sformatf("v%0d_stall_cycles", id), 64'(nst), 64'(lat));
    chk($sformatf("v%0d_result", id), result_o, v.exp);
    chk($sformatf("v%0d_stall_at_ready", id), 64'(stallreq_o), 64'd0);
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d_ready_drop", id), 64'(ready_o), 64'd0);
    last_res = v.exp;
  endtask

  initial begin
    int n, nst;
    bit seen;
    vec[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                33, 1'b0};
    vec[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},   33, 1'b0};
    vec[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},          33, 1'b0};
    vec[3]  = '{1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFFFFFF},          2,  1'b0};
    vec[4]  = '{1'b0, 32'd3,          32'd10,         {32'd3, 32'd0},                 33, 1'b1};
    vec[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF},          33, 1'b0};
    vec[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},          33, 1'b0};
    vec[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'd3},          33, 1'b0};
    vec[8]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0, 32'd1},                 33, 1'b0};
    vec[9]  = '{1'b1, 32'd0,          32'd5,          {32'd0, 32'd0},                 33, 1'b1};
    vec[10] = '{1'b0, 32'h80000000,   32'd2,          {32'd0, 32'h40000000},          33, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 11; i++) run_div(i, vec[i]);

    // annul during iteration 10 of 1000/3, request withdrawn with it
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk); annul_i = 1'b1;
    #1 chk("annul_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o) seen = 1'b1;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    chk("annul_result_kept", result_o, last_res);
    run_div(20, '{1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0});

    // start and annul together in IDLE: annul wins, latency counts from annul release
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); annul_i = 1'b0;
    wait_ready(n, nst);
    chk("annul_start_latency", 64'(n), 64'd33);
    chk("annul_start_result", result_o, {32'd2, 32'd14});
    // annul in END with start still high
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1;
    chk("annul_end_ready", 64'(ready_o), 64'd0);
    chk("annul_end_result", result_o, {32'd2, 32'd14});
    @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
    repeat (2) @(posedge clk);

    // async reset at iteration 20 of 100/7, then restart from the held request
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (21) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    @(negedge clk); rst = 1'b1;
    wait_ready(n, nst);
    chk("rst_restart_latency", 64'(n), 64'd33);
    chk("rst_restart_result", result_o, {32'd2, 32'd14});
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_restart_drop", 64'(ready_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative multi-cycle divider and its sequencer, serving the execute stage for DIV/DIVU.
- Execute holds the request with operands; this block runs a restoring division one quotient bit per clock.
- It asserts `stallreq_o` so the pipeline freezes until the result is ready.
- It returns `{remainder, quotient}` for the HI/LO write path.
- It owns the divider datapath; execute only requests, waits, and consumes.

## Interface
Parameters:
- `WIDTH`, 32, operand width. Quotient and remainder are each `WIDTH` bits.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  divide request. Held high with stable operands until `ready_o` is seen.
- `annul_i`  in  1  flush. Cancels any operation in progress.
- `signed_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  WIDTH  dividend.
- `opdata2_i`  in  WIDTH  divisor.
- `result_o`  out  2*WIDTH  `{remainder, quotient}`, registered.
- `ready_o`  out  1  result valid, registered.
- `stallreq_o`  out  1  pipeline stall request to the stall controller.

## Operation
States:
- **IDLE**
  - `start_i & ~annul_i`: if divisor is 0, go to BYZERO; otherwise latch absolute values (when signed), clear counter and partial remainder, go to ON.
  - `annul_i` blocks any start.
- **ON**
  - Per clock: shift `{rem, dvd}` left by 1; trial-subtract the divisor from the upper `WIDTH+1` bits; if the result is non-negative, keep it and set quotient bit 1, else quotient bit 0.
  - Counter increments per iteration; after `WIDTH` iterations go to END.
  - `annul_i` → IDLE.
- **BYZERO**
  - Load quotient = all ones, remainder = dividend (raw input, no sign fix); go to END.
  - `annul_i` → IDLE.
- **END**
  - `ready_o`=1, `result_o` valid.
  - Stay while `start_i`=1; go to IDLE when `start_i`=0 or `annul_i`=1.

Sign fix:
- Applied on the ON→END transition when `signed_i`.
- Quotient is negated if the operand signs differ.
- Remainder takes the sign of the dividend.
- 0x80000000 / −1 → quotient 0x80000000, remainder 0 (wraps, no trap).

Arithmetic:
- Trial subtract is WIDTH+1 bits wide; the carry/sign bit decides the quotient bit.
- Counter is `$clog2(WIDTH)+1` bits.

Stall:
- `stallreq_o = start_i & ~annul_i & ~ready_o` (combinational).

## Timing
- Reset values: state IDLE, `result_o`=0, `ready_o`=0, counter 0.
- `stallreq_o` follows its equation.
- Edge 0 samples `start_i` in IDLE, then WIDTH ON edges, then one edge into END.
- `ready_o` rises after edge WIDTH+1, i.e. 33 cycles for WIDTH=32.
- Divide by zero: `ready_o` rises after edge 2.
- `stallreq_o` is high from the first cycle `start_i` is high until the cycle `ready_o` is high. The pipeline advances on the edge ending the `ready_o` cycle.
- `ready_o` stays high until the clock after `start_i` drops. Execute must drop `start_i` in the cycle after consuming the result.
- A new `start_i` in the same cycle END exits is ignored. The request is re-sampled in IDLE one cycle later.
- `annul_i` in any cycle: state is IDLE after the next edge, `ready_o`=0, `result_o` keeps its last value.
- Annul and start in the same IDLE cycle: annul wins.
- Operands are sampled only in IDLE. Changes during ON are ignored.
- Async reset mid-operation: immediate return to reset values, no pending result.

## Configuration
`DIV_EARLY_OUT_EN`:
- **Defined:** in IDLE, if |dividend| < |divisor| (unsigned compare of absolute values, divisor ≠ 0), skip ON. Load quotient 0, remainder = raw dividend, go straight to END. `ready_o` rises after edge 1.
- **Undefined:** every nonzero-divisor operation takes the full WIDTH iterations; results are identical.

## Test plan
- DIVU 100/7: `stallreq_o` high 33 cycles, then `ready_o` with `result_o` = `{32'd2, 32'd14}`; drop `start_i` → IDLE next edge.
- DIV −7/2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- DIVU 5/0: `ready_o` after 2 edges, `result_o` = `{32'd5, 32'hFFFFFFFF}`.
- DIVU 1000/3 with `annul_i` pulsed in iteration 10: IDLE next edge, `ready_o` never asserts. A following 9/3 completes with quotient 3, remainder 0.
- DIVU 3/10: with `DIV_EARLY_OUT_EN`, `ready_o` after 1 edge with `{32'd3, 32'd0}`; without it, after 33 edges, same result.
- Assert `rst` low at iteration 20 of 100/7: all outputs go to reset values at once. After release, the held `start_i` restarts the operation and completes correctly.
